mat3_stream_loader: RTL



---
 rtl/mat3_stream_loader.sv | 87 ++++++++
 1 files changed

// File: rtl/mat3_stream_loader.sv
// mat3_stream_loader: ping-pong 3x3 matrix assembler for the determinant stage.
// Define MATLOAD_COLMAJOR_EN to accept elements in column-major order (default row-major).
module mat3_stream_loader #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [DATA_W-1:0] O11,
   output logic [DATA_W-1:0] O12,
   output logic [DATA_W-1:0] O13,
   output logic [DATA_W-1:0] O21,
   output logic [DATA_W-1:0] O22,
   output logic [DATA_W-1:0] O23,
   output logic [DATA_W-1:0] O31,
   output logic [DATA_W-1:0] O32,
   output logic [DATA_W-1:0] O33,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err_frame
);
   logic [DATA_W-1:0] bank [0:1][0:8];
   logic [1:0]        full;
   logic              wr_sel;
   logic              rd_sel;
   logic [3:0]        idx;
   logic [3:0]        pos;
   logic              accept;
`ifdef MATLOAD_COLMAJOR_EN
   // slot (row-major O position) for each arrival index; upper nibbles pad unused idx codes
   localparam logic [63:0] COL_MAP = {28'h0, 4'd8, 4'd5, 4'd2, 4'd7, 4'd4, 4'd1, 4'd6, 4'd3, 4'd0};
   // column-major arrival: element idx lands at row idx%3, column idx/3
   always_comb pos = COL_MAP[{idx, 2'b00} +: 4];
`else
   // row-major arrival: element idx lands directly in slot idx
   always_comb pos = idx;
`endif
   assign in_ready  = !rst && !full[wr_sel];
   assign accept    = in_valid && in_ready;
   assign out_valid = full[rd_sel];
   // gate the outputs so a bank still being filled is never visible
   assign O11 = out_valid ? bank[rd_sel][0] : '0;
   assign O12 = out_valid ? bank[rd_sel][1] : '0;
   assign O13 = out_valid ? bank[rd_sel][2] : '0;
   assign O21 = out_valid ? bank[rd_sel][3] : '0;
   assign O22 = out_valid ? bank[rd_sel][4] : '0;
   assign O23 = out_valid ? bank[rd_sel][5] : '0;
   assign O31 = out_valid ? bank[rd_sel][6] : '0;
   assign O32 = out_valid ? bank[rd_sel][7] : '0;
   assign O33 = out_valid ? bank[rd_sel][8] : '0;
   // fill side and release side touch different banks, so both may act in one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < 9; k++)
               bank[b][k] <= '0;
         full      <= '0;
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
         idx       <= '0;
         err_frame <= 1'b0;
      end else begin
         err_frame <= 1'b0;
         if (accept) begin
            bank[wr_sel][pos] <= in_data;
            if (idx == 4'd8) begin
               full[wr_sel] <= 1'b1;
               wr_sel       <= !wr_sel;
               idx          <= '0;
               err_frame    <= !in_last;
            end else if (in_last) begin
               idx       <= '0;
               err_frame <= 1'b1;
            end else begin
               idx <= idx + 4'd1;
            end
         end
         if (out_valid && out_ready) begin
            full[rd_sel] <= 1'b0;
            rd_sel       <= !rd_sel;
         end
      end
   end
endmodule
